// File: rtl/ceyloniac_mc_sequencer.sv
// Multi-cycle control sequencer for the CEYLONIAC core: FSM, PC/IR/MDR/ALUOut/EPC/cause
// registers, datapath strobes and a req/ack memory port with wait states and bus timeout.
module ceyloniac_mc_sequencer #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          ADDR_WIDTH  = 10,
    parameter int unsigned PC_RESET    = 32'h0,
    parameter int unsigned EXC_VECTOR  = 32'h80,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            opcode,
    input  logic                  overflow,
    input  logic                  zero,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] jump_target,
    input  logic [DATA_WIDTH-1:0] store_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [DATA_WIDTH-1:0] ir_out,
    output logic [DATA_WIDTH-1:0] mdr_out,
    output logic [DATA_WIDTH-1:0] alu_out,
    output logic [DATA_WIDTH-1:0] epc_out,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic [1:0]            cause_out,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  alu_src_a,
    output logic                  epc_write,
    output logic                  cause_write,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            alu_op,
    output logic [3:0]            current_state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_EXC       = 4'd10
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
    localparam logic [1:0] CAUSE_OVF     = 2'd1;
    localparam logic [1:0] CAUSE_BUS     = 2'd2;

    localparam logic [DATA_WIDTH-1:0] PcReset   = DATA_WIDTH'(PC_RESET);
    localparam logic [DATA_WIDTH-1:0] ExcVector = DATA_WIDTH'(EXC_VECTOR);
    localparam bit                    TimeoutOn = (MEM_TIMEOUT > 0);
    localparam int                    TW        = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]         TLimit    = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
    logic [DATA_WIDTH-1:0] aluout_q, aluout_d;
    logic [DATA_WIDTH-1:0] epc_q, epc_d;
    logic [1:0]            cause_q, cause_d;
    logic [1:0]            pcause_q, pcause_d;
    logic                  pfetch_q, pfetch_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;

    logic       memState, waitCycle, timeoutHit;
    logic       reqC, weC, addrAluC, irWrC, regWrC, regDstC, memToRegC;
    logic       srcAC, epcWrC, causeWrC;
    logic [1:0] srcBC, aluOpC;

    assign memState   = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    assign waitCycle  = memState && !mem_ack;
    assign timeoutHit = TimeoutOn && waitCycle && (tcnt_q == TLimit);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        mdr_d     = mdr_q;
        epc_d     = epc_q;
        cause_d   = cause_q;
        pcause_d  = pcause_q;
        pfetch_d  = pfetch_q;
        aluout_d  = alu_result;
        reqC      = 1'b0;
        weC       = 1'b0;
        addrAluC  = 1'b0;
        irWrC     = 1'b0;
        regWrC    = 1'b0;
        regDstC   = 1'b0;
        memToRegC = 1'b0;
        srcAC     = 1'b0;
        srcBC     = 2'b00;
        aluOpC    = 2'b00;
        epcWrC    = 1'b0;
        causeWrC  = 1'b0;

        case (state_q)
            S_FETCH: begin
                reqC  = 1'b1;
                srcBC = 2'b01;
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    irWrC   = 1'b1;
                    pc_d    = alu_result;
                    state_d = S_DECODE;
                end else if (timeoutHit) begin
                    pcause_d = CAUSE_BUS;
                    pfetch_d = 1'b1;
                    state_d  = S_EXC;
                end
            end
            S_DECODE: begin
                srcBC = 2'b11;
                case (opcode)
                    OP_RTYPE:      state_d = S_EXECUTE;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    default: begin
                        pcause_d = CAUSE_ILLEGAL;
                        pfetch_d = 1'b0;
                        state_d  = S_EXC;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                srcAC   = 1'b1;
                srcBC   = 2'b10;
                state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            // ALUOut is frozen while a data access waits so the bus address stays stable.
            S_MEM_READ: begin
                reqC     = 1'b1;
                addrAluC = 1'b1;
                aluout_d = aluout_q;
                if (mem_ack) begin
                    mdr_d   = mem_rdata;
                    state_d = S_MEM_WB;
                end else if (timeoutHit) begin
                    pcause_d = CAUSE_BUS;
                    pfetch_d = 1'b0;
                    state_d  = S_EXC;
                end
            end
            S_MEM_WB: begin
                regWrC    = 1'b1;
                memToRegC = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_WRITE: begin
                reqC     = 1'b1;
                weC      = 1'b1;
                addrAluC = 1'b1;
                aluout_d = aluout_q;
                if (mem_ack) begin
                    state_d = S_FETCH;
                end else if (timeoutHit) begin
                    pcause_d = CAUSE_BUS;
                    pfetch_d = 1'b0;
                    state_d  = S_EXC;
                end
            end
            S_EXECUTE: begin
                srcAC  = 1'b1;
                aluOpC = 2'b10;
                if (overflow) begin
                    pcause_d = CAUSE_OVF;
                    pfetch_d = 1'b0;
                    state_d  = S_EXC;
                end else begin
                    state_d = S_R_WB;
                end
            end
            S_R_WB: begin
                regWrC  = 1'b1;
                regDstC = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                srcAC  = 1'b1;
                aluOpC = 2'b01;
                if (zero) begin
                    pc_d = aluout_q;
                end
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_d    = jump_target;
                state_d = S_FETCH;
            end
            // A fetch timeout has not advanced the PC yet; every other fault has.
            S_EXC: begin
                epcWrC   = 1'b1;
                causeWrC = 1'b1;
                epc_d    = pfetch_q ? pc_q : pc_q - DATA_WIDTH'(4);
                cause_d  = pcause_q;
                pc_d     = ExcVector;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (TimeoutOn && waitCycle && (state_d == state_q)) begin
            tcnt_d = tcnt_q + TW'(1);
        end else begin
            tcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            pc_q     <= PcReset;
            ir_q     <= '0;
            mdr_q    <= '0;
            aluout_q <= '0;
            epc_q    <= '0;
            cause_q  <= '0;
            pcause_q <= '0;
            pfetch_q <= 1'b0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mdr_q    <= mdr_d;
            aluout_q <= aluout_d;
            epc_q    <= epc_d;
            cause_q  <= cause_d;
            pcause_q <= pcause_d;
            pfetch_q <= pfetch_d;
            tcnt_q   <= tcnt_d;
        end
    end

    // Reset overrides every strobe combinationally so an in-flight access is dropped at once.
    assign mem_req     = reset & reqC;
    assign mem_we      = reset & weC;
    assign ir_write    = reset & irWrC;
    assign reg_write   = reset & regWrC;
    assign reg_dst     = reset & regDstC;
    assign mem_to_reg  = reset & memToRegC;
    assign alu_src_a   = reset & srcAC;
    assign epc_write   = reset & epcWrC;
    assign cause_write = reset & causeWrC;
    assign alu_src_b   = reset ? srcBC : 2'b00;
    assign alu_op      = reset ? aluOpC : 2'b00;

    assign mem_addr  = addrAluC ? aluout_q[ADDR_WIDTH+1:2] : pc_q[ADDR_WIDTH+1:2];
    assign mem_wdata = mem_we ? store_data : '0;

    assign ir_out        = ir_q;
    assign mdr_out       = mdr_q;
    assign alu_out       = aluout_q;
    assign epc_out       = epc_q;
    assign pc_out        = pc_q;
    assign cause_out     = cause_q;
    assign current_state = state_q;

endmodule

// File: tb/tb_ceyloniac_mc_sequencer.sv
// Directed bench for ceyloniac_mc_sequencer: a 32-bit instance driven by a small ALU model
// and a 16-bit instance with wrapping PC and the bus timeout disabled.
module tb_ceyloniac_mc_sequencer;

    logic        clk;
    logic        reset, reset16;
    logic [5:0]  opcode, opcode16;
    logic        overflow, zero;
    logic [31:0] alu_result, jump_target, store_data, mem_rdata;
    logic        mem_ack;
    logic        mem_req, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, ir_out, mdr_out, alu_out, epc_out, pc_out;
    logic [1:0]  cause_out, alu_src_b, alu_op;
    logic        ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, epc_write, cause_write;
    logic [3:0]  current_state;

    logic [15:0] aluResult16, memRdata16, mWdata16, irOut16, mdrOut16, aluOut16, epcOut16, pcOut16;
    logic        memAck16, mReq16, mWe16;
    logic [7:0]  mAddr16;
    logic [1:0]  cause16, srcB16, aluOp16;
    logic        irWr16, regWr16, regDst16, memToReg16, srcA16, epcWr16, causeWr16;
    logic [3:0]  state16;

    logic [31:0] regA, regB, aluA, aluB;
    logic [15:0] imm;

    int total = 0;
    int bad   = 0;

    ceyloniac_mc_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .PC_RESET(32'h0),
                             .EXC_VECTOR(32'h80), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .overflow(overflow), .zero(zero),
        .alu_result(alu_result), .jump_target(jump_target), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ir_out(ir_out), .mdr_out(mdr_out),
        .alu_out(alu_out), .epc_out(epc_out), .pc_out(pc_out), .cause_out(cause_out),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .epc_write(epc_write), .cause_write(cause_write),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .current_state(current_state)
    );

    ceyloniac_mc_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .PC_RESET(32'hFFFC),
                             .EXC_VECTOR(32'h40), .MEM_TIMEOUT(0)) dut16 (
        .clk(clk), .reset(reset16), .opcode(opcode16), .overflow(1'b0), .zero(1'b0),
        .alu_result(aluResult16), .jump_target(16'h0), .store_data(16'h0),
        .mem_req(mReq16), .mem_we(mWe16), .mem_addr(mAddr16), .mem_wdata(mWdata16),
        .mem_rdata(memRdata16), .mem_ack(memAck16), .ir_out(irOut16), .mdr_out(mdrOut16),
        .alu_out(aluOut16), .epc_out(epcOut16), .pc_out(pcOut16), .cause_out(cause16),
        .ir_write(irWr16), .reg_write(regWr16), .reg_dst(regDst16), .mem_to_reg(memToReg16),
        .alu_src_a(srcA16), .epc_write(epcWr16), .cause_write(causeWr16),
        .alu_src_b(srcB16), .alu_op(aluOp16), .current_state(state16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath ALU stand-in: operand muxes and add/sub steered by the sequencer strobes.
    always_comb begin
        aluA = alu_src_a ? regA : pc_out;
        aluB = regB;
        case (alu_src_b)
            2'b00:   aluB = regB;
            2'b01:   aluB = 32'd4;
            2'b10:   aluB = {{16{imm[15]}}, imm};
            default: aluB = {{14{imm[15]}}, imm, 2'b00};
        endcase
        alu_result = (alu_op == 2'b01) ? aluA - aluB : aluA + aluB;
    end

    assign aluResult16 = pcOut16 + ((srcB16 == 2'b01) ? 16'd4 : 16'd0);

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Fetch handshake: holds the instruction opcode and acks after the given wait cycles.
    task automatic applyStimulus(input logic [5:0] op, input int waits);
        opcode    = op;
        mem_rdata = {op, 26'h0000820};
        mem_ack   = 1'b0;
        repeat (waits) tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick(); tick();
        total++; if (current_state !== 4'd0) begin bad++; $display("[TB] FAIL rst_state got=%0d want=0", current_state); end
        total++; if (pc_out !== 32'h0) begin bad++; $display("[TB] FAIL rst_pc got=%0h want=0", pc_out); end
        total++; if ({ir_out, mdr_out, alu_out, epc_out} !== 128'h0) begin bad++; $display("[TB] FAIL rst_regs ir=%0h mdr=%0h alu=%0h epc=%0h want=0", ir_out, mdr_out, alu_out, epc_out); end
        total++; if (cause_out !== 2'd0) begin bad++; $display("[TB] FAIL rst_cause got=%0d want=0", cause_out); end
        total++; if ({mem_req, ir_write, reg_write, epc_write} !== 4'b0) begin bad++; $display("[TB] FAIL rst_strobes got=%b want=0000", {mem_req, ir_write, reg_write, epc_write}); end
        reset = 1'b1; mem_ack = 1'b0;
        #1;
        total++; if (mem_req !== 1'b1 || mem_addr !== 10'h0) begin bad++; $display("[TB] FAIL rst_release req=%b addr=%0h want req=1 addr=0", mem_req, mem_addr); end
    endtask

    task automatic test_rtype();
        opcode = 6'h00; mem_rdata = 32'h00221820; mem_ack = 1'b1;
        #1;
        total++; if (ir_write !== 1'b1 || alu_src_b !== 2'b01) begin bad++; $display("[TB] FAIL r_fetch irw=%b srcb=%b want 1/01", ir_write, alu_src_b); end
        tick(); mem_ack = 1'b0;
        total++; if (current_state !== 4'd1 || pc_out !== 32'h4 || ir_out !== 32'h00221820) begin bad++; $display("[TB] FAIL r_decode st=%0d pc=%0h ir=%0h want 1/4/00221820", current_state, pc_out, ir_out); end
        tick();
        total++; if (current_state !== 4'd6 || alu_op !== 2'b10 || alu_src_a !== 1'b1 || reg_write !== 1'b0) begin bad++; $display("[TB] FAIL r_exec st=%0d op=%b srca=%b rw=%b want 6/10/1/0", current_state, alu_op, alu_src_a, reg_write); end
        tick();
        total++; if (current_state !== 4'd7 || reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0) begin bad++; $display("[TB] FAIL r_wb st=%0d rw=%b rd=%b m2r=%b want 7/1/1/0", current_state, reg_write, reg_dst, mem_to_reg); end
        tick();
        total++; if (current_state !== 4'd0 || pc_out !== 32'h4) begin bad++; $display("[TB] FAIL r_done st=%0d pc=%0h want 0/4", current_state, pc_out); end
    endtask

    task automatic test_lw_wait();
        regA = 32'h100; regB = 32'h7; imm = 16'h0010;
        applyStimulus(6'h23, 0);
        tick();
        total++; if (current_state !== 4'd2 || alu_src_a !== 1'b1 || alu_src_b !== 2'b10) begin bad++; $display("[TB] FAIL lw_addr st=%0d srca=%b srcb=%b want 2/1/10", current_state, alu_src_a, alu_src_b); end
        tick();
        for (int i = 0; i < 3; i++) begin
            total++; if (current_state !== 4'd3 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h44) begin bad++; $display("[TB] FAIL lw_wait%0d st=%0d req=%b we=%b addr=%0h want 3/1/0/44", i, current_state, mem_req, mem_we, mem_addr); end
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1;
        total++; if (mem_req !== 1'b1 || mem_addr !== 10'h44) begin bad++; $display("[TB] FAIL lw_ackcyc req=%b addr=%0h want 1/44", mem_req, mem_addr); end
        tick(); mem_ack = 1'b0;
        total++; if (current_state !== 4'd4 || mdr_out !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL lw_mdr st=%0d mdr=%0h want 4/deadbeef", current_state, mdr_out); end
        total++; if ({reg_write, mem_to_reg, reg_dst} !== 3'b110) begin bad++; $display("[TB] FAIL lw_wb got=%b want 110", {reg_write, mem_to_reg, reg_dst}); end
        tick();
        total++; if (current_state !== 4'd0 || pc_out !== 32'h8) begin bad++; $display("[TB] FAIL lw_done st=%0d pc=%0h want 0/8", current_state, pc_out); end
    endtask

    task automatic test_jump_branch();
        jump_target = 32'h10;
        applyStimulus(6'h02, 0);
        tick();
        total++; if (current_state !== 4'd9) begin bad++; $display("[TB] FAIL j_state got=%0d want 9", current_state); end
        tick();
        total++; if (pc_out !== 32'h10) begin bad++; $display("[TB] FAIL j_pc got=%0h want 10", pc_out); end
        imm = 16'd3; zero = 1'b1;
        applyStimulus(6'h04, 0);
        tick();
        total++; if (current_state !== 4'd8 || alu_out !== 32'h20 || alu_op !== 2'b01) begin bad++; $display("[TB] FAIL beq_state st=%0d aluout=%0h op=%b want 8/20/01", current_state, alu_out, alu_op); end
        tick();
        total++; if (current_state !== 4'd0 || pc_out !== 32'h20) begin bad++; $display("[TB] FAIL beq_taken pc=%0h want 20", pc_out); end
        applyStimulus(6'h02, 0);
        tick(); tick();
        zero = 1'b0;
        applyStimulus(6'h04, 0);
        tick(); tick();
        total++; if (current_state !== 4'd0 || pc_out !== 32'h14) begin bad++; $display("[TB] FAIL beq_nottaken pc=%0h want 14", pc_out); end
    endtask

    task automatic test_exceptions();
        applyStimulus(6'h3F, 0);
        tick();
        total++; if (current_state !== 4'd10 || epc_write !== 1'b1 || cause_write !== 1'b1) begin bad++; $display("[TB] FAIL ill_exc st=%0d epcw=%b cw=%b want 10/1/1", current_state, epc_write, cause_write); end
        tick();
        total++; if (cause_out !== 2'd0 || epc_out !== 32'h14 || pc_out !== 32'h80) begin bad++; $display("[TB] FAIL ill_regs cause=%0d epc=%0h pc=%0h want 0/14/80", cause_out, epc_out, pc_out); end
        applyStimulus(6'h00, 0);
        tick(); overflow = 1'b1;
        #1;
        total++; if (current_state !== 4'd6 || reg_write !== 1'b0) begin bad++; $display("[TB] FAIL ovf_exec st=%0d rw=%b want 6/0", current_state, reg_write); end
        tick(); overflow = 1'b0;
        total++; if (current_state !== 4'd10 || reg_write !== 1'b0) begin bad++; $display("[TB] FAIL ovf_exc st=%0d rw=%b want 10/0", current_state, reg_write); end
        tick();
        total++; if (cause_out !== 2'd1 || epc_out !== 32'h80 || pc_out !== 32'h80) begin bad++; $display("[TB] FAIL ovf_regs cause=%0d epc=%0h pc=%0h want 1/80/80", cause_out, epc_out, pc_out); end
    endtask

    task automatic test_timeout();
        mem_ack = 1'b0;
        repeat (15) tick();
        total++; if (current_state !== 4'd0 || mem_req !== 1'b1) begin bad++; $display("[TB] FAIL to_cyc16 st=%0d req=%b want 0/1", current_state, mem_req); end
        tick();
        total++; if (current_state !== 4'd10 || mem_req !== 1'b0) begin bad++; $display("[TB] FAIL to_exc st=%0d req=%b want 10/0", current_state, mem_req); end
        tick();
        total++; if (cause_out !== 2'd2 || epc_out !== 32'h80 || pc_out !== 32'h80) begin bad++; $display("[TB] FAIL to_regs cause=%0d epc=%0h pc=%0h want 2/80/80", cause_out, epc_out, pc_out); end
        repeat (15) tick();
        opcode = 6'h00; mem_rdata = 32'h00221820; mem_ack = 1'b1;
        tick(); mem_ack = 1'b0;
        total++; if (current_state !== 4'd1 || pc_out !== 32'h84) begin bad++; $display("[TB] FAIL to_ack16 st=%0d pc=%0h want 1/84", current_state, pc_out); end
        tick(); tick(); tick();
        regA = 32'h200; imm = 16'h0008; store_data = 32'hCAFEF00D;
        applyStimulus(6'h2B, 0);
        tick(); tick();
        total++; if (current_state !== 4'd5 || mem_we !== 1'b1 || mem_wdata !== 32'hCAFEF00D || mem_addr !== 10'h82) begin bad++; $display("[TB] FAIL sw_write st=%0d we=%b wd=%0h addr=%0h want 5/1/cafef00d/82", current_state, mem_we, mem_wdata, mem_addr); end
        repeat (16) tick();
        total++; if (current_state !== 4'd10 || mem_req !== 1'b0) begin bad++; $display("[TB] FAIL sw_to st=%0d req=%b want 10/0", current_state, mem_req); end
        tick();
        total++; if (cause_out !== 2'd2 || epc_out !== 32'h84 || pc_out !== 32'h80) begin bad++; $display("[TB] FAIL sw_to_regs cause=%0d epc=%0h pc=%0h want 2/84/80", cause_out, epc_out, pc_out); end
    endtask

    task automatic test_reset_abort();
        applyStimulus(6'h2B, 0);
        tick(); tick(); tick();
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBADC0DE0;
        #1;
        total++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_wdata !== 32'h0) begin bad++; $display("[TB] FAIL abort_same req=%b we=%b wd=%0h want 0/0/0", mem_req, mem_we, mem_wdata); end
        tick();
        total++; if (current_state !== 4'd0 || pc_out !== 32'h0) begin bad++; $display("[TB] FAIL abort_edge st=%0d pc=%0h want 0/0", current_state, pc_out); end
        reset = 1'b1; mem_ack = 1'b0;
        #1;
        total++; if (mem_req !== 1'b1 || ir_out !== 32'h0) begin bad++; $display("[TB] FAIL abort_after req=%b ir=%0h want 1/0", mem_req, ir_out); end
    endtask

    task automatic test_narrow();
        tick();
        total++; if (state16 !== 4'd0 || pcOut16 !== 16'hFFFC || mAddr16 !== 8'hFF || mReq16 !== 1'b0) begin bad++; $display("[TB] FAIL n_rst st=%0d pc=%0h addr=%0h req=%b want 0/fffc/ff/0", state16, pcOut16, mAddr16, mReq16); end
        reset16 = 1'b1; opcode16 = 6'h3F; memRdata16 = 16'hFC00; memAck16 = 1'b1;
        tick(); memAck16 = 1'b0;
        total++; if (state16 !== 4'd1 || pcOut16 !== 16'h0000 || irOut16 !== 16'hFC00) begin bad++; $display("[TB] FAIL n_wrap st=%0d pc=%0h ir=%0h want 1/0/fc00", state16, pcOut16, irOut16); end
        tick(); tick();
        total++; if (cause16 !== 2'd0 || epcOut16 !== 16'hFFFC || pcOut16 !== 16'h0040) begin bad++; $display("[TB] FAIL n_exc cause=%0d epc=%0h pc=%0h want 0/fffc/40", cause16, epcOut16, pcOut16); end
        repeat (20) tick();
        total++; if (state16 !== 4'd0 || mReq16 !== 1'b1 || mAddr16 !== 8'h10) begin bad++; $display("[TB] FAIL n_notimeout st=%0d req=%b addr=%0h want 0/1/10", state16, mReq16, mAddr16); end
    endtask

    initial begin
        reset = 1'b0; reset16 = 1'b0;
        opcode = 6'h0; opcode16 = 6'h0; overflow = 1'b0; zero = 1'b0;
        jump_target = 32'h0; store_data = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        memRdata16 = 16'h0; memAck16 = 1'b0;
        regA = 32'h0; regB = 32'h0; imm = 16'h0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_jump_branch();
        test_exceptions();
        test_timeout();
        test_reset_abort();
        test_narrow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
